// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, FSM states and ALU op encoding for the
// multi-cycle core
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_BAD
  } alu_op_t;

  // ALU_BAD marks an undefined funct so the caller can treat the R-type as illegal
  function automatic alu_op_t alu_decode(input logic [5:0] funct);
    case (funct)
      FN_ADDU: return ALU_ADD;
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// rtl/mips_mc_regfile.sv - 32x32 register file, two async read ports, one sync write
// port, R0 hardwired to zero
module mips_mc_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  // Contents are deliberately left unreset; entry 0 is never written
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc.sv
// rtl/mips_mc.sv - multi-cycle MIPS-I subset core (addu/subu/and/or/slt/addiu/lw/sw/
// beq/j) sharing a single memory port between fetch and data access
module mips_mc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [31:0]      pc_dbg
);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [CNT_W-1:0] retired_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  alu_op_t     alu_op;
  logic [31:0] alu_result;
  logic        op_legal, is_sw;
  logic [31:0] rf_rd1, rf_rd2;
  logic        rf_we, retire;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_op   = alu_decode(funct);
  assign is_sw    = (opcode == OP_SW);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE:                              op_legal = (alu_op != ALU_BAD);
      OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW:  op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = a_q + b_q;
      ALU_SUB: alu_result = a_q - b_q;
      ALU_AND: alu_result = a_q & b_q;
      ALU_OR:  alu_result = a_q | b_q;
      ALU_SLT: alu_result = {31'd0, ($signed(a_q) < $signed(b_q))};
      default: alu_result = 32'd0;
    endcase
  end

  mips_mc_regfile u_regfile (
    .clk (clk),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  assign rf_wa = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wd = (opcode == OP_LW) ? mdr_q : alu_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!op_legal) begin
          state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE, OP_ADDIU: state_d = S_WB;
            OP_LW, OP_SW:       state_d = S_MEM;
            default:            state_d = S_FETCH;
          endcase
        end
      end
      S_MEM:    if (mem_ack) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // mem_req is gated by rst so an in-flight request drops the moment reset asserts
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    retire  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: mem_req = rst;
      S_EXEC:  retire  = op_legal ? ((opcode == OP_BEQ) || (opcode == OP_J))
                                  : !HALT_ON_ILLEGAL;
      S_MEM: begin
        mem_req = rst;
        mem_we  = is_sw;
        retire  = mem_ack && is_sw;
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  assign mem_addr  = (state_q == S_MEM) ? {alu_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
  assign mem_wdata = b_q;
  assign retired   = retired_q;
  assign pc_dbg    = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_q     <= 32'd0;
      mdr_q     <= 32'd0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + 32'd4;
          end
        end
        // Branch target is precomputed here so EXEC only has to compare
        S_DECODE: begin
          a_q   <= rf_rd1;
          b_q   <= rf_rd2;
          alu_q <= pc_q + {imm_sext[29:0], 2'b00};
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE:             alu_q <= alu_result;
            OP_ADDIU, OP_LW, OP_SW: alu_q <= a_q + imm_sext;
            OP_BEQ:               if (a_q == b_q) pc_q <= alu_q;
            OP_J:                 pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            default:              ;
          endcase
        end
        S_MEM: begin
          if (mem_ack && !is_sw) mdr_q <= mem_rdata;
        end
        default: ;
      endcase
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_mc.sv
// tb/tb_mips_mc.sv - self-checking bench for mips_mc with a wait-state memory model
// and store/fetch scoreboards
module tb_mips_mc;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;
  localparam logic [31:0] NOP = 32'h2400_0000;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
  logic [31:0] retired;

  logic [31:0] mem [0:1023];
  logic [63:0] load_q [$];
  logic [63:0] wr_log [$];
  logic [63:0] exp_wr [$];
  logic [31:0] rd_log [$];
  logic [31:0] exp_rd [$];

  int ack_delay;
  int wait_cnt;
  int stab_checks, stab_errs, halt_req_seen;
  logic        pend_v;
  logic [31:0] pend_addr, pend_wdata;
  logic        pend_we;

  int n_checks, n_fail;

  mips_mc #(.RESET_PC(RST_PC), .CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .retired   (retired),
    .pc_dbg    (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (mem_req && mem_ack) wait_cnt <= 0;
    else if (mem_req) wait_cnt <= wait_cnt + 1;
  end

  // Memory side effects, program loading and request-stability monitoring
  always @(negedge clk) begin
    logic [63:0] e;
    while (load_q.size() > 0) begin
      e = load_q.pop_front();
      mem[e[41:32]] = e[31:0];
    end
    if (mem_req) begin
      if (pend_v) begin
        stab_checks++;
        if (mem_addr !== pend_addr || mem_we !== pend_we || (mem_we && mem_wdata !== pend_wdata))
          stab_errs++;
      end
      pend_v = !mem_ack;
      pend_addr = mem_addr; pend_we = mem_we; pend_wdata = mem_wdata;
      if (mem_ack) begin
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          wr_log.push_back({mem_addr, mem_wdata});
        end else begin
          rd_log.push_back(mem_addr);
        end
      end
    end else begin
      pend_v = 1'b0;
    end
    if (halted && mem_req) halt_req_seen++;
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_q.push_back({22'd0, addr[11:2], data});
  endtask

  task automatic begin_test(input int d);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = d;
    wr_log.delete(); rd_log.delete(); exp_wr.delete(); exp_rd.delete();
    stab_checks = 0; stab_errs = 0; halt_req_seen = 0;
  endtask

  task automatic release_rst;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    begin_test(0);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_checks++; if (pc_dbg !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_dbg, RST_PC); end
    load(32'h0, ILLEGAL);
    release_rst();
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RST_PC) begin
      n_fail++; $display("FAIL first_fetch: req=%0b we=%0b addr=%h want 1 0 %h", mem_req, mem_we, mem_addr, RST_PC);
    end
  endtask

  task automatic test_alu_seq;
    int cyc;
    logic [63:0] e, a;
    begin_test(0);
    load(32'h00, enc_i(6'h09, 5'd0, 5'd1, 16'd5));
    load(32'h04, enc_i(6'h09, 5'd0, 5'd2, 16'd7));
    load(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
    load(32'h0C, enc_r(5'd1, 5'd2, 5'd5, 6'h23));
    load(32'h10, enc_r(5'd1, 5'd2, 5'd6, 6'h24));
    load(32'h14, enc_r(5'd1, 5'd2, 5'd7, 6'h25));
    load(32'h18, enc_i(6'h09, 5'd0, 5'd8, 16'hFFFF));
    load(32'h1C, enc_i(6'h09, 5'd0, 5'd11, 16'd1));
    load(32'h20, enc_r(5'd8, 5'd11, 5'd9, 6'h2A));
    load(32'h24, enc_r(5'd11, 5'd8, 5'd10, 6'h2A));
    load(32'h28, enc_i(6'h09, 5'd0, 5'd0, 16'd9));
    load(32'h2C, enc_i(6'h2B, 5'd0, 5'd3, 16'h100)); exp_wr.push_back({32'h100, 32'd12});
    load(32'h30, enc_i(6'h2B, 5'd0, 5'd5, 16'h104)); exp_wr.push_back({32'h104, 32'hFFFF_FFFE});
    load(32'h34, enc_i(6'h2B, 5'd0, 5'd6, 16'h108)); exp_wr.push_back({32'h108, 32'd5});
    load(32'h38, enc_i(6'h2B, 5'd0, 5'd7, 16'h10C)); exp_wr.push_back({32'h10C, 32'd7});
    load(32'h3C, enc_i(6'h2B, 5'd0, 5'd9, 16'h110)); exp_wr.push_back({32'h110, 32'd1});
    load(32'h40, enc_i(6'h2B, 5'd0, 5'd10, 16'h114)); exp_wr.push_back({32'h114, 32'd0});
    load(32'h44, enc_i(6'h2B, 5'd0, 5'd0, 16'h118)); exp_wr.push_back({32'h118, 32'd0});
    load(32'h48, ILLEGAL);
    release_rst();
    repeat (12) @(negedge clk);
    n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL retired_12cyc: got %0d want 3", retired); end
    n_checks++; if (pc_dbg !== 32'hC) begin n_fail++; $display("FAIL pc_12cyc: got %h want c", pc_dbg); end
    cyc = 0;
    while (!halted && cyc < 1000) begin @(negedge clk); cyc++; end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL alu_halt_timeout: halted=%0b want 1", halted); end
    n_checks++; if (retired !== 32'd18) begin n_fail++; $display("FAIL alu_retired: got %0d want 18", retired); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (wr_log.size() == 0) begin n_fail++; $display("FAIL alu_store_missing: got none want %h", e); end
      else begin
        a = wr_log.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL alu_store: got %h want %h", a, e); end
      end
    end
    n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL alu_extra_stores: got %0d want 0", wr_log.size()); end
  endtask

  task automatic test_mem_wait;
    int cyc;
    logic [63:0] e, a;
    begin_test(3);
    load(32'h000, {6'h02, 26'h40});
    load(32'h100, enc_i(6'h09, 5'd0, 5'd1, 16'd5));
    load(32'h104, enc_i(6'h09, 5'd0, 5'd2, 16'd7));
    load(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
    load(32'h10C, enc_i(6'h2B, 5'd0, 5'd3, 16'h10)); exp_wr.push_back({32'h10, 32'd12});
    load(32'h110, enc_i(6'h23, 5'd0, 5'd4, 16'h10));
    load(32'h114, enc_i(6'h2B, 5'd0, 5'd4, 16'h14)); exp_wr.push_back({32'h14, 32'd12});
    load(32'h118, ILLEGAL);
    release_rst();
    cyc = 0;
    while (!halted && cyc < 2000) begin @(negedge clk); cyc++; end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL wait_halt_timeout: halted=%0b want 1", halted); end
    n_checks++; if (retired !== 32'd7) begin n_fail++; $display("FAIL wait_retired: got %0d want 7", retired); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (wr_log.size() == 0) begin n_fail++; $display("FAIL wait_store_missing: got none want %h", e); end
      else begin
        a = wr_log.pop_front();
        if (a !== e) begin n_fail++; $display("FAIL wait_store: got %h want %h", a, e); end
      end
    end
    n_checks++; if (stab_errs !== 0) begin n_fail++; $display("FAIL wait_stability: got %0d unstable cycles want 0", stab_errs); end
    n_checks++; if (stab_checks !== 33) begin n_fail++; $display("FAIL wait_cycles: got %0d held cycles want 33", stab_checks); end
  endtask

  task automatic test_branch_jump;
    int cyc;
    logic [31:0] er, ar;
    logic [63:0] a;
    begin_test(1);
    load(32'h00, enc_i(6'h09, 5'd0, 5'd1, 16'd3));
    for (int i = 1; i < 8; i++) load(32'(i * 4), NOP);
    for (int i = 0; i <= 8; i++) exp_rd.push_back(32'(i * 4));
    load(32'h20, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    load(32'h24, enc_i(6'h2B, 5'd0, 5'd1, 16'h200));
    load(32'h28, enc_i(6'h2B, 5'd0, 5'd1, 16'h204));
    load(32'h2C, {6'h02, 26'h100});
    load(32'h30, ILLEGAL);
    load(32'h400, enc_i(6'h2B, 5'd0, 5'd1, 16'h208));
    load(32'h404, enc_i(6'h04, 5'd1, 5'd0, 16'd5));
    load(32'h408, ILLEGAL);
    exp_rd.push_back(32'h2C); exp_rd.push_back(32'h400);
    exp_rd.push_back(32'h404); exp_rd.push_back(32'h408);
    release_rst();
    cyc = 0;
    while (!halted && cyc < 1000) begin @(negedge clk); cyc++; end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL br_halt_timeout: halted=%0b want 1", halted); end
    n_checks++; if (retired !== 32'd12) begin n_fail++; $display("FAIL br_retired: got %0d want 12", retired); end
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front();
      n_checks++;
      if (rd_log.size() == 0) begin n_fail++; $display("FAIL br_fetch_missing: got none want %h", er); end
      else begin
        ar = rd_log.pop_front();
        if (ar !== er) begin n_fail++; $display("FAIL br_fetch_addr: got %h want %h", ar, er); end
      end
    end
    n_checks++;
    if (wr_log.size() != 1) begin n_fail++; $display("FAIL br_store_count: got %0d want 1", wr_log.size()); end
    else begin
      a = wr_log.pop_front();
      if (a !== {32'h208, 32'd3}) begin n_fail++; $display("FAIL br_store: got %h want %h", a, {32'h208, 32'd3}); end
    end
  endtask

  task automatic test_illegal_halt;
    int cyc;
    begin_test(0);
    load(32'h00, enc_i(6'h09, 5'd0, 5'd1, 16'd1));
    load(32'h04, ILLEGAL);
    release_rst();
    cyc = 0;
    while (!halted && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halt_timeout: halted=%0b want 1", halted); end
    repeat (20) @(negedge clk);
    n_checks++; if (halt_req_seen !== 0) begin n_fail++; $display("FAIL ill_mem_req: got %0d req cycles want 0", halt_req_seen); end
    n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL ill_retired: got %0d want 1", retired); end
    n_checks++; if (pc_dbg !== 32'h8) begin n_fail++; $display("FAIL ill_pc: got %h want 8", pc_dbg); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (halted !== 1'b0 || pc_dbg !== RST_PC || retired !== 32'd0) begin
      n_fail++; $display("FAIL ill_reset: halted=%0b pc=%h retired=%0d want 0 %h 0", halted, pc_dbg, retired, RST_PC);
    end
  endtask

  task automatic test_reset_mid_mem;
    int cyc;
    logic [63:0] a;
    begin_test(10);
    load(32'h00, enc_i(6'h09, 5'd0, 5'd1, 16'd4));
    load(32'h04, enc_i(6'h2B, 5'd0, 5'd1, 16'h40));
    load(32'h08, ILLEGAL);
    release_rst();
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_reach_mem: we=%0b want 1", mem_we); end
    n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL mid_retired_pre: got %0d want 1", retired); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %0b want 0", mem_req); end
    n_checks++; if (retired !== 32'd0 || pc_dbg !== RST_PC) begin
      n_fail++; $display("FAIL mid_reset_state: retired=%0d pc=%h want 0 %h", retired, pc_dbg, RST_PC);
    end
    @(negedge clk);
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RST_PC || retired !== 32'd0) begin
      n_fail++; $display("FAIL mid_refetch: req=%0b we=%0b addr=%h retired=%0d want 1 0 %h 0", mem_req, mem_we, mem_addr, retired, RST_PC);
    end
    n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL mid_discarded: got %0d stores want 0", wr_log.size()); end
    cyc = 0;
    while (!halted && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++;
    if (wr_log.size() != 1) begin n_fail++; $display("FAIL mid_store_count: got %0d want 1", wr_log.size()); end
    else begin
      a = wr_log.pop_front();
      if (a !== {32'h40, 32'd4}) begin n_fail++; $display("FAIL mid_store: got %h want %h", a, {32'h40, 32'd4}); end
    end
  endtask

  initial begin
    rst = 1'b0;
    ack_delay = 0;
    n_checks = 0;
    n_fail = 0;
    pend_v = 1'b0;
    test_reset();
    test_alu_seq();
    test_mem_wait();
    test_branch_jump();
    test_illegal_halt();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
